// File: rtl/count_event_monitor_if.sv
// Event drain port of count_event_monitor: FWFT head plus valid/ready handshake.
// The record width follows COUNT_EVT_TIMESTAMP_EN (36 bits with timestamp, else 20).
interface count_event_monitor_if #(
`ifdef COUNT_EVT_TIMESTAMP_EN
    parameter int EW = 36
`else
    parameter int EW = 20
`endif
);
    logic          evt_valid;
    logic          evt_ready;
    logic [EW-1:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/count_event_monitor.sv
// Classifies each enabled counter sample (match/ovf/unf/jump) and queues flagged samples in a FWFT FIFO.
// Optional COUNT_EVT_TIMESTAMP_EN prepends a 16-bit free-running cycle stamp to every record.
module count_event_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] CMP_RESET = 16'h0000,
    parameter int          DROP_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            count_in,
    input  logic                   count_en,
    input  logic                   cmp_we,
    input  logic [15:0]            cmp_wdata,
    input  logic                   clear,
    count_event_monitor_if.master  evt,
    output logic [$clog2(DEPTH):0] evt_level,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   drop_sticky
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef COUNT_EVT_TIMESTAMP_EN
    localparam int EW = 36;
`else
    localparam int EW = 20;
`endif

    typedef struct packed {
        logic jump;
        logic unf;
        logic ovf;
        logic match;
    } flags_t;

    logic [15:0]   cmp_reg;
    logic [15:0]   prev_cnt;
    logic          prev_vld;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [EW-1:0] mem [DEPTH];
`ifdef COUNT_EVT_TIMESTAMP_EN
    logic [15:0]   ts;
`endif

    logic [15:0]   diff;
    flags_t        flags;
    logic [EW-1:0] rec;
    logic          push, pop, full, do_write, drop;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        flags = '0;
        diff  = count_in - prev_cnt;
        flags.match = (count_in == cmp_reg) && (!prev_vld || diff != 16'd0);
        flags.ovf   = prev_vld && (prev_cnt == 16'hFFFF) && (count_in == 16'h0000);
        flags.unf   = prev_vld && (prev_cnt == 16'h0000) && (count_in == 16'hFFFF);
        flags.jump  = prev_vld && !(diff == 16'd0 || diff == 16'd1 || diff == 16'hFFFF);
    end

`ifdef COUNT_EVT_TIMESTAMP_EN
    assign rec = {ts, flags, count_in};
`else
    assign rec = {flags, count_in};
`endif

    assign push     = count_en && (flags != '0);
    assign pop      = evt.evt_valid && evt.evt_ready;
    assign full     = (level == LW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_write = push && (!full || pop);
    assign drop     = push && full && !pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_reg     <= CMP_RESET;
            prev_cnt    <= '0;
            prev_vld    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            drop_cnt    <= '0;
            drop_sticky <= 1'b0;
`ifdef COUNT_EVT_TIMESTAMP_EN
            ts          <= '0;
`endif
        end else begin
            if (cmp_we) cmp_reg <= cmp_wdata;
            if (clear) begin
                prev_vld    <= 1'b0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                level       <= '0;
                drop_cnt    <= '0;
                drop_sticky <= 1'b0;
`ifdef COUNT_EVT_TIMESTAMP_EN
                ts          <= '0;
`endif
            end else begin
`ifdef COUNT_EVT_TIMESTAMP_EN
                ts <= ts + 16'd1;
`endif
                if (count_en) begin
                    prev_cnt <= count_in;
                    prev_vld <= 1'b1;
                end
                if (do_write) wr_ptr <= wr_ptr + AW'(1);
                if (pop)      rd_ptr <= rd_ptr + AW'(1);
                case ({do_write, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
                if (drop) begin
                    drop_sticky <= 1'b1;
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_write && !reset && !clear) mem[wr_ptr] <= rec;
    end

    assign evt.evt_valid = (level != '0);
    assign evt.evt_data  = evt.evt_valid ? mem[rd_ptr] : '0;
    assign evt_level     = level;
endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream stage of the 16-bit up/down loadable counter. Samples the counter's data_out every enabled cycle and classifies each step: compare match, overflow wrap (0xFFFF->0x0000), underflow wrap (0x0000->0xFFFF), or jump (load or illegal step).
- Queues one event record per flagged sample in an internal FIFO, drained through a valid/ready port by the status/trace logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CMP_RESET, 16'h0000, reset value of the compare register.
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- count_in  input  16  counter data_out
- count_en  input  1  sample qualifier; tied to the counter's enable/load activity
- cmp_we  input  1  write strobe for compare register
- cmp_wdata  input  16  compare value
- clear  input  1  synchronous flush (FIFO, history, drop count); compare register kept
- evt_valid  output  1  FIFO head valid
- evt_ready  input  1  consumer accepts head
- evt_data  output  EW  {flags[3:0]={jump,unf,ovf,match}, count[15:0]}; EW=20, or 36 with the optional feature
- evt_level  output  $clog2(DEPTH)+1  FIFO occupancy
- drop_cnt  output  DROP_W  events lost to a full FIFO, saturating
- drop_sticky  output  1  set on first drop; cleared only by reset/clear

Behaviour:
- Reset values: evt_valid=0, evt_data=0, evt_level=0, drop_cnt=0, drop_sticky=0, cmp_reg=CMP_RESET, prev_vld=0, prev_cnt=0.
- Sampling happens at an edge where count_en=1. Flags are computed combinationally from count_in, prev_cnt, prev_vld, and cmp_reg. At that edge prev_cnt<=count_in and prev_vld<=1. With count_en=0, all history is held.
- diff = count_in - prev_cnt, taken modulo 2^16.
- match: count_in==cmp_reg and (!prev_vld or count_in!=prev_cnt). A held count therefore does not re-fire.
- ovf: prev_vld, prev_cnt==16'hFFFF, count_in==16'h0000.
- unf: prev_vld, prev_cnt==16'h0000, count_in==16'hFFFF.
- jump: prev_vld and diff not in {0, 1, 16'hFFFF}.
- The first sample after reset/clear can raise only match.
- Multiple flags in one sample produce one record with several bits set (e.g. match+ovf).
- A record is pushed when any flag is set. The push and the prev update occur at the same edge.
- Latency: sample at edge N -> with an empty FIFO, evt_valid=1 with that record in the cycle after edge N.
- FIFO is first-word-fall-through: evt_data is the head whenever evt_valid=1. Pop happens at an edge with evt_valid&&evt_ready. evt_data is don't-care when evt_valid=0.
- Full FIFO with a push and no pop: record is dropped, drop_cnt increments (saturates at all-ones), drop_sticky<=1.
- Full FIFO with a push and a pop in the same cycle: both happen, no drop, level unchanged.
- Empty FIFO with a push and evt_ready=1: no bypass; the pop happens the following cycle.
- cmp_we: cmp_reg<=cmp_wdata at the edge. The new value is used for samples from the next edge onward. A cmp_we coinciding with a sample matches against the old value.
- clear: FIFO empties, evt_valid=0 next cycle, prev_vld=0, drop_cnt=0, drop_sticky=0. clear wins over a simultaneous push/pop. cmp_reg is unchanged.
- reset mid-operation: everything returns to reset values at that edge, including in-flight records.
- Pointer arithmetic uses log2(DEPTH) bits with wrap. evt_level is derived from an extra-bit occupancy counter, 0..DEPTH.

Optional Feature:
- Macro: COUNT_EVT_TIMESTAMP_EN.
- Defined: a free-running 16-bit cycle counter ts is added. It resets to 0 on reset/clear, increments every cycle, and wraps 0xFFFF->0. ts at the push edge is appended: evt_data = {ts[15:0], flags, count}, EW=36.
- Undefined: no ts logic, EW=20.

Test Plan:
- Reset, cmp_we with 16'h0005, count_en=1, count_in steps 0..7 -> exactly one record {match, 16'h0005}, evt_valid rises the cycle after the sample edge.
- count_in 16'hFFFE, 16'hFFFF, 16'h0000 -> one record flags=ovf, count=0. Then 0x0000 -> 0xFFFF gives flags=unf, count=0xFFFF.
- cmp_reg=0, count_in 0xFFFF -> 0x0000 -> single record flags=4'b0011 (ovf+match). count_in 0x0010 -> 0x0100 -> flags=jump, count=0x0100. Holding 0x0100 with count_en=1 for 5 cycles -> no records.
- DEPTH=8, evt_ready=0, 10 jumps -> evt_level=8, drop_cnt=2, drop_sticky=1. Then a push and a pop in the same cycle while full -> no drop, level stays 8.
- Assert clear while FIFO holds 4 records -> evt_valid=0 and evt_level=0 next cycle, drop_cnt=0, cmp_reg retained. Next sample can raise only match (no jump).
- With COUNT_EVT_TIMESTAMP_EN defined: a match sampled 20 cycles after reset release -> evt_data[35:20]=16'd20. With the macro undefined: evt_data is 20 bits.
